// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the folded FIR sequencer
package fir_pkg;

    localparam int FIR_N    = 16;
    localparam int FIR_TAPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Symmetric low-pass kernel loaded at reset; taps beyond index 7 are zero.
    function automatic logic [15:0] default_coef(input int k);
        case (k)
            0:       return 16'd16;
            1:       return 16'd17;
            2:       return 16'd18;
            3:       return 16'd19;
            4:       return 16'd19;
            5:       return 16'd18;
            6:       return 16'd17;
            7:       return 16'd16;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - runtime-programmable coefficient register file
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int N    = FIR_N,
    parameter int TAPS = FIR_TAPS,
    parameter int AW   = $clog2(FIR_TAPS)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] coef_q [TAPS];
    logic [N-1:0] coef_d [TAPS];

    // Single write port; the write is visible from the following cycle.
    always_comb begin
        coef_d = coef_q;
        if (we) begin
            coef_d[waddr] = wdata;
        end
    end

    // Coefficient storage, reverting to the default kernel on reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= N'(default_coef(i));
            end
        end else begin
            coef_q <= coef_d;
        end
    end

    assign rdata = coef_q[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - folded FIR: one shared MAC stepping over all taps
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int N    = FIR_N,
    parameter int TAPS = FIR_TAPS,
    parameter int AW   = $clog2(FIR_TAPS)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    output logic          coef_drop,
    output logic          busy
);

    fir_state_e    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          coef_drop_q, coef_drop_d;
    logic [N-1:0]  dly_q [TAPS];
    logic [N-1:0]  dly_d [TAPS];

    logic [AW-1:0] rd_addr;
    logic [N-1:0]  sample_rd;
    logic [N-1:0]  coef_rd;
    logic [N-1:0]  prod;
    logic          coef_wr_ok;

    // Coefficients may only change while no computation is in flight.
    assign coef_wr_ok = coef_we && (state_q == IDLE);

    fir_coef_bank #(
        .N    (N),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_coef_bank (
        .Clk   (Clk),
        .reset (reset),
        .we    (coef_wr_ok),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (tap_q),
        .rdata (coef_rd)
    );

    // Tap k reads x[n-k]: walk backwards from the newest sample, wrapping mod TAPS.
    assign rd_addr   = base_q - tap_q;
    assign sample_rd = dly_q[rd_addr];
    assign prod      = coef_rd * sample_rd;

    // Next-state, datapath and handshake logic for IDLE -> MAC -> OUT.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        base_d      = base_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        dly_d       = dly_q;
        coef_drop_d = coef_we && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dly_d[wptr_q] = in_data;
                    base_d        = wptr_q;
                    wptr_d        = wptr_q + AW'(1);
                    acc_d         = '0;
                    tap_d         = '0;
                    state_d       = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod;
                tap_d = tap_q + AW'(1);
                if (tap_q == AW'(TAPS - 1)) begin
                    out_data_d  = acc_q + prod;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            base_q      <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            coef_drop_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            base_q      <= base_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_drop_q <= coef_drop_d;
            dly_q       <= dly_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_drop = coef_drop_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for the folded FIR sequencer
module tb_fir_mac_sequencer;

    localparam int N    = 16;
    localparam int TAPS = 8;
    localparam int AW   = 3;

    logic          Clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic          coef_drop;
    logic          busy;

    fir_mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_drop (coef_drop),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: history shift register (m_hist[0] is newest) and coefficients.
    logic [N-1:0] m_coef [TAPS];
    logic [N-1:0] m_hist [TAPS];
    logic [N-1:0] exp_q [$];
    int           last_accept = 0;
    logic         prev_valid  = 1'b0;

    task automatic model_reset();
        logic [N-1:0] dflt [TAPS];
        dflt = '{16'd16, 16'd17, 16'd18, 16'd19, 16'd19, 16'd18, 16'd17, 16'd16};
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = dflt[k];
            m_hist[k] = '0;
        end
        exp_q.delete();
        prev_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] model_filter();
        logic [N-1:0] acc;
        logic [N-1:0] p;
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            p   = m_coef[k] * m_hist[k];
            acc = acc + p;
        end
        return acc;
    endfunction

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Monitor: models accepts/coef writes and scores outputs at each falling edge.
    initial forever begin
        @(negedge Clk);
        if (reset) begin
            model_reset();
        end else begin
            if (out_valid && !prev_valid) begin
                check("latency", 32'(cyc - last_accept), 32'(TAPS));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_data), 32'hDEAD_BEEF);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (coef_we && in_ready) begin
                m_coef[coef_addr] = coef_data;
            end
            if (in_valid && in_ready) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    m_hist[k] = m_hist[k-1];
                end
                m_hist[0] = in_data;
                exp_q.push_back(model_filter());
                last_accept = cyc + 1;
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [N-1:0] d);
        @(posedge Clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (in_ready) break;
        end
        check("send_accept", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clk);
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic coef_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        @(posedge Clk);
        #1;
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge Clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;

        @(negedge Clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_coef_drop", 32'(coef_drop), 32'd0);

        out_ready = 1'b1;

        // Impulse response, then step response on top of the zeroed history.
        send(16'd1);
        for (int i = 0; i < 8; i++) send(16'd0);
        drain();
        for (int i = 0; i < 8; i++) send(16'd1);
        drain();
        check("step_last", 32'(out_data), 32'd140);

        // Coefficient write in IDLE, then a dropped write during MAC.
        for (int i = 0; i < 8; i++) send(16'd0);
        drain();
        coef_write(3'd0, 16'd100);
        send(16'd1);
        drain();
        check("coef_b0", 32'(out_data), 32'd100);
        for (int i = 0; i < 7; i++) send(16'd0);
        drain();
        send(16'd0);
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'd555;
        @(negedge Clk);
        check("drop_busy", 32'(busy), 32'd1);
        check("drop_before", 32'(coef_drop), 32'd0);
        @(posedge Clk);
        #1;
        coef_we = 1'b0;
        @(negedge Clk);
        check("drop_pulse", 32'(coef_drop), 32'd1);
        @(negedge Clk);
        check("drop_end", 32'(coef_drop), 32'd0);
        drain();
        send(16'd1);
        drain();
        check("coef_kept", 32'(out_data), 32'd100);

        // Wrap: a full-scale sample against the default kernel.
        do_reset();
        send(16'hFFFF);
        drain();
        check("wrap", 32'(out_data), 32'h0000_FFF0);

        // Backpressure: result held, no new accept until the handshake.
        out_ready = 1'b0;
        send(16'd5);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (out_valid) break;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        held = out_data;
        @(posedge Clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_stable", 32'(out_data), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            @(posedge Clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (in_ready) break;
        end
        check("bp_accept", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of MAC: partial result lost, defaults restored.
        coef_write(3'd0, 16'd200);
        send(16'd3);
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge Clk);
        #1;
        reset = 1'b0;
        send(16'd1);
        drain();
        check("post_rst_impulse", 32'(out_data), 32'd16);

        repeat (3) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
